// File: rtl/mouse_sprite_render.sv
// Mouse-pointer overlay: rectangle hit test, sprite RAM addressing and colour-keyed compositing (3-cycle pipe).
// Optional POINTER_SCALE2_EN draws the pointer at 2x with each sprite texel covering 2x2 pixels.
module mouse_sprite_render #(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    COORD_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR   = 12'hF0F
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [COORD_WIDTH-1:0] x_i,
  input  logic [COORD_WIDTH-1:0] y_i,
  input  logic                   video_on_i,
  input  logic [DATA_WIDTH-1:0]  bg_rgb_i,
  input  logic                   frame_start_i,
  input  logic [COORD_WIDTH-1:0] mouse_x_i,
  input  logic [COORD_WIDTH-1:0] mouse_y_i,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  input  logic [DATA_WIDTH-1:0]  ram_dout_i,
  output logic [DATA_WIDTH-1:0]  rgb_out_o,
  output logic                   in_sprite_o
);

  localparam int HALF = ADDR_WIDTH / 2;
`ifdef POINTER_SCALE2_EN
  localparam logic [COORD_WIDTH:0] WIN = (COORD_WIDTH+1)'(2 ** (HALF + 1));
`else
  localparam logic [COORD_WIDTH:0] WIN = (COORD_WIDTH+1)'(2 ** HALF);
`endif

  logic [COORD_WIDTH-1:0] pos_x_q, pos_y_q;
  logic [COORD_WIDTH:0]   dx, dy;
  logic                   hit;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic                   hit_d1_q, hit_d2_q, vid_d1_q, vid_d2_q;
  logic [DATA_WIDTH-1:0]  bg_d1_q, bg_d2_q;
  logic [DATA_WIDTH-1:0]  rgb_q, rgb_d;
  logic                   in_sprite_q, in_sprite_d;
  logic                   opaque;

  // Subtraction is one bit wider so x < pos never aliases into the window.
  assign dx  = {1'b0, x_i} - {1'b0, pos_x_q};
  assign dy  = {1'b0, y_i} - {1'b0, pos_y_q};
  assign hit = (x_i >= pos_x_q) && (y_i >= pos_y_q) && (dx < WIN) && (dy < WIN);

  always_comb begin
    ram_addr_d = ram_addr_q;
    if (hit) begin
`ifdef POINTER_SCALE2_EN
      ram_addr_d = {dy[HALF:1], dx[HALF:1]};
`else
      ram_addr_d = {dy[HALF-1:0], dx[HALF-1:0]};
`endif
    end
  end

  assign opaque      = hit_d2_q && (ram_dout_i != KEY_COLOR);
  assign in_sprite_d = vid_d2_q && opaque;

  always_comb begin
    rgb_d = '0;
    if (vid_d2_q) rgb_d = opaque ? ram_dout_i : bg_d2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      ram_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      vid_d1_q    <= 1'b0;
      vid_d2_q    <= 1'b0;
      bg_d1_q     <= '0;
      bg_d2_q     <= '0;
      rgb_q       <= '0;
      in_sprite_q <= 1'b0;
    end else begin
      // Position only moves at frame start; the current pixel still sees the old one.
      if (frame_start_i) begin
        pos_x_q <= mouse_x_i;
        pos_y_q <= mouse_y_i;
      end
      ram_addr_q  <= ram_addr_d;
      hit_d1_q    <= hit;
      vid_d1_q    <= video_on_i;
      bg_d1_q     <= bg_rgb_i;
      hit_d2_q    <= hit_d1_q;
      vid_d2_q    <= vid_d1_q;
      bg_d2_q     <= bg_d1_q;
      rgb_q       <= rgb_d;
      in_sprite_q <= in_sprite_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign rgb_out_o   = rgb_q;
  assign in_sprite_o = in_sprite_q;

endmodule

// File: tb/tb_mouse_sprite_render.sv
// Directed bench for mouse_sprite_render with a behavioural 1-cycle sprite RAM.
// Honours POINTER_SCALE2_EN when defined for the build.
module tb_mouse_sprite_render;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y, mouse_x, mouse_y;
  logic        video_on, frame_start;
  logic [11:0] bg_rgb, ram_dout, rgb_out;
  logic [9:0]  ram_addr;
  logic        in_sprite;
  logic [11:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) ram_dout <= mem[ram_addr];

  mouse_sprite_render dut (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .y_i(y), .video_on_i(video_on),
    .bg_rgb_i(bg_rgb), .frame_start_i(frame_start), .mouse_x_i(mouse_x),
    .mouse_y_i(mouse_y), .ram_addr_o(ram_addr), .ram_dout_i(ram_dout),
    .rgb_out_o(rgb_out), .in_sprite_o(in_sprite)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    x = 11'd2047; y = 11'd2047; video_on = 1'b0; bg_rgb = 12'h000; frame_start = 1'b0;
  endtask

  // Drive one pixel, then idle; check ram_addr at +1 and rgb_out/in_sprite at +3.
  task automatic pix(input string tag, input logic [10:0] px, input logic [10:0] py,
                     input logic vid, input logic [11:0] bg, input logic fs,
                     input logic [9:0] ea, input logic [11:0] ergb, input logic ein);
    x = px; y = py; video_on = vid; bg_rgb = bg; frame_start = fs;
    @(posedge clk); #1;
    chk({tag, ".addr"}, 32'(ram_addr), 32'(ea));
    idle();
    @(posedge clk); @(posedge clk); #1;
    chk({tag, ".rgb"}, 32'(rgb_out), 32'(ergb));
    chk({tag, ".in"}, 32'(in_sprite), 32'(ein));
  endtask

  task automatic latch(input logic [10:0] mx, input logic [10:0] my);
    mouse_x = mx; mouse_y = my; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 12'hAAA;
    mem[1023] = 12'h0F0;
    mem[0]    = 12'hF0F;
    mem[179]  = 12'hABC;
    mem[330]  = 12'h321;
    mem[33]   = 12'h777;
    mem[65]   = 12'h555;
    mem[1]    = 12'h0C3;

    // Reset with random activity on every input
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = 11'($urandom); y = 11'($urandom); video_on = 1'($urandom);
      bg_rgb = 12'($urandom); frame_start = 1'($urandom);
      mouse_x = 11'($urandom); mouse_y = 11'($urandom);
      @(posedge clk); #1;
    end
    chk("rst.addr", 32'(ram_addr), 32'd0);
    chk("rst.rgb", 32'(rgb_out), 32'd0);
    chk("rst.in", 32'(in_sprite), 32'd0);

    // After release, the flushed pipe shows black for two edges, then the first pixel
    idle();
    video_on = 1'b1; bg_rgb = 12'h5A5; mouse_x = 11'd900; mouse_y = 11'd900;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel1.rgb", 32'(rgb_out), 32'd0);
    idle();
    @(posedge clk); #1;
    chk("rel2.rgb", 32'(rgb_out), 32'd0);
    @(posedge clk); #1;
    chk("rel3.rgb", 32'(rgb_out), 32'h5A5);
    chk("rel3.addr", 32'(ram_addr), 32'd0);
    // pos must still be (0,0): pixel (1,1) hits
`ifdef POINTER_SCALE2_EN
    pix("pos0", 11'd1, 11'd1, 1'b1, 12'h111, 1'b0, 10'd0, 12'hF0F == 12'hF0F ? 12'h111 : 12'h0, 1'b0);
`else
    pix("pos0", 11'd1, 11'd1, 1'b1, 12'h111, 1'b0, 10'd33, 12'h777, 1'b1);
`endif

`ifdef POINTER_SCALE2_EN
    latch(11'd0, 11'd0);
    pix("s2.corner", 11'd63, 11'd63, 1'b1, 12'h222, 1'b0, 10'd1023, 12'h0F0, 1'b1);
    pix("s2.miss",   11'd64, 11'd63, 1'b1, 12'h222, 1'b0, 10'd1023, 12'h222, 1'b0);
    pix("s2.texel",  11'd2,  11'd0,  1'b1, 12'h222, 1'b0, 10'd1,    12'h0C3, 1'b1);
    pix("s2.texel3", 11'd3,  11'd1,  1'b1, 12'h222, 1'b0, 10'd1,    12'h0C3, 1'b1);
`else
    latch(11'd100, 11'd50);
    pix("t2.hit",   11'd131, 11'd81, 1'b1, 12'h999, 1'b0, 10'd1023, 12'h0F0, 1'b1);
    pix("t3.miss",  11'd132, 11'd81, 1'b1, 12'h123, 1'b0, 10'd1023, 12'h123, 1'b0);
    pix("t3.key",   11'd100, 11'd50, 1'b1, 12'h456, 1'b0, 10'd0,    12'h456, 1'b0);
    pix("t3.above", 11'd100, 11'd49, 1'b1, 12'h321, 1'b0, 10'd0,    12'h321, 1'b0);
    pix("t3.left",  11'd99,  11'd50, 1'b1, 12'h654, 1'b0, 10'd0,    12'h654, 1'b0);

    latch(11'd620, 11'd0);
    pix("t4.edge",  11'd639, 11'd5,  1'b1, 12'h010, 1'b0, 10'd179, 12'hABC, 1'b1);
    pix("t4.miss",  11'd619, 11'd5,  1'b1, 12'h020, 1'b0, 10'd179, 12'h020, 1'b0);
    pix("t4.blank", 11'd639, 11'd5,  1'b0, 12'h030, 1'b0, 10'd179, 12'h000, 1'b0);

    // Mouse moves without frame_start: old position still in force
    mouse_x = 11'd300; mouse_y = 11'd300;
    pix("t5.old",   11'd630, 11'd10,  1'b1, 12'h040, 1'b0, 10'd330, 12'h321, 1'b1);
    pix("t5.nohit", 11'd301, 11'd301, 1'b1, 12'h050, 1'b0, 10'd330, 12'h050, 1'b0);
    latch(11'd300, 11'd300);
    pix("t5.new",   11'd301, 11'd301, 1'b1, 12'h060, 1'b0, 10'd33,  12'h777, 1'b1);

    // frame_start on a hit pixel: that pixel uses the old position, the next the new one
    mouse_x = 11'd1000; mouse_y = 11'd1000;
    pix("fs.same",  11'd301, 11'd302, 1'b1, 12'h070, 1'b1, 10'd65,  12'h555, 1'b1);
    pix("fs.next",  11'd301, 11'd302, 1'b1, 12'h080, 1'b0, 10'd65,  12'h080, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
